// File: rtl/wb_regfile_pkg.sv
// Shared MIPS pipeline constants for the write-back stage and the register file.
// Width defaults and the hard-wired zero register index live here.
package wb_regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int REG_ZERO   = 0;
    localparam int COUNT_W    = 32;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_if.sv
// MEM/WB write-back bus plus the decode-stage and debug read ports of the register file.
// There is no valid/ready handshake: WB_RegWrite_In qualifies a write in the cycle it is high.
interface wb_regfile_if
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              WB_RegWrite_In;
    logic              WB_MemtoReg_In;
    logic [DATA_W-1:0] WB_readData_In;
    logic [DATA_W-1:0] WB_ALUresult_In;
    logic [ADDR_W-1:0] WB_Index_WriteReg_In;
    logic [ADDR_W-1:0] ID_ReadReg1_In;
    logic [ADDR_W-1:0] ID_ReadReg2_In;
    logic [ADDR_W-1:0] Dbg_Addr_In;

    logic [DATA_W-1:0]  ID_ReadData1_Out;
    logic [DATA_W-1:0]  ID_ReadData2_Out;
    logic [DATA_W-1:0]  WB_WriteData_Out;
    logic [DATA_W-1:0]  Dbg_Data_Out;
    logic [COUNT_W-1:0] WB_WriteCount_Out;

    modport master (
        output WB_RegWrite_In, WB_MemtoReg_In, WB_readData_In, WB_ALUresult_In,
        output WB_Index_WriteReg_In, ID_ReadReg1_In, ID_ReadReg2_In, Dbg_Addr_In,
        input  ID_ReadData1_Out, ID_ReadData2_Out, WB_WriteData_Out, Dbg_Data_Out,
        input  WB_WriteCount_Out
    );

    modport slave (
        input  WB_RegWrite_In, WB_MemtoReg_In, WB_readData_In, WB_ALUresult_In,
        input  WB_Index_WriteReg_In, ID_ReadReg1_In, ID_ReadReg2_In, Dbg_Addr_In,
        output ID_ReadData1_Out, ID_ReadData2_Out, WB_WriteData_Out, Dbg_Data_Out,
        output WB_WriteCount_Out
    );

endinterface : wb_regfile_if

// File: rtl/wb_regfile_wb_select.sv
// Write-back data select: memory read data or ALU result, purely combinational.
module wb_select
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              mem_to_reg_i,
    input  logic [DATA_W-1:0] read_data_i,
    input  logic [DATA_W-1:0] alu_result_i,
    output logic [DATA_W-1:0] write_data_o
);

    assign write_data_o = mem_to_reg_i ? read_data_i : alu_result_i;

endmodule : wb_select

// File: rtl/wb_regfile.sv
// MIPS register file with write-through bypass, hard-wired zero register,
// a debug read port and a committed-write counter.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic         clk,
    input  logic         reset,
    wb_regfile_if.slave  bus
);

    localparam int              NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0]  regs_q [NUM_REGS];
    logic [COUNT_W-1:0] wr_count_q;
    logic [COUNT_W-1:0] wr_count_d;
    logic [DATA_W-1:0]  write_data;
    logic               commit;

    wb_select #(.DATA_W(DATA_W)) u_wb_select (
        .mem_to_reg_i (bus.WB_MemtoReg_In),
        .read_data_i  (bus.WB_readData_In),
        .alu_result_i (bus.WB_ALUresult_In),
        .write_data_o (write_data)
    );

    // Reset gates commit so neither storage, counter nor bypass see an in-flight write.
    assign commit = bus.WB_RegWrite_In && (bus.WB_Index_WriteReg_In != ZERO_IDX) && !reset;

    assign wr_count_d = commit ? (wr_count_q + COUNT_W'(1)) : wr_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            if (commit) begin
                regs_q[bus.WB_Index_WriteReg_In] <= write_data;
            end
            wr_count_q <= wr_count_d;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] idx,
        input logic              in_reset,
        input logic              wr_active,
        input logic [ADDR_W-1:0] wr_idx,
        input logic [DATA_W-1:0] wr_data,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] val;
        val = '0;
        if (!in_reset && (idx != ZERO_IDX)) begin
            val = (wr_active && (idx == wr_idx)) ? wr_data : stored;
        end
        return val;
    endfunction

    always_comb begin
        bus.ID_ReadData1_Out = read_port(bus.ID_ReadReg1_In, reset, commit,
                                         bus.WB_Index_WriteReg_In, write_data,
                                         regs_q[bus.ID_ReadReg1_In]);
        bus.ID_ReadData2_Out = read_port(bus.ID_ReadReg2_In, reset, commit,
                                         bus.WB_Index_WriteReg_In, write_data,
                                         regs_q[bus.ID_ReadReg2_In]);
        bus.Dbg_Data_Out     = read_port(bus.Dbg_Addr_In, reset, commit,
                                         bus.WB_Index_WriteReg_In, write_data,
                                         regs_q[bus.Dbg_Addr_In]);
    end

    assign bus.WB_WriteData_Out  = write_data;
    assign bus.WB_WriteCount_Out = wr_count_q;

endmodule : wb_regfile
